// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment display path.
//   DIGIT_W   : width of one hex digit (nibble).
//   SEG_0..F  : active-high segment patterns, bit order gfedcba (bit 0 = a).
//   SEG_BLANK : all segments off.
//   PHASE_*   : blink phase encodings used by the display driver.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [0:0] PHASE_OFF = 1'b0;
    localparam logic [0:0] PHASE_ON  = 1'b1;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: pure combinational hex nibble to 7-segment decoder.
//   nibble : input hex digit 0..F.
//   segs   : active-high segment pattern, segs[0]=a .. segs[6]=g.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic [6:0]         segs
);

    always_comb begin
        segs = SEG_BLANK;
        unique case (nibble)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = SEG_A;
            4'hB: segs = SEG_B;
            4'hC: segs = SEG_C;
            4'hD: segs = SEG_D;
            4'hE: segs = SEG_E;
            4'hF: segs = SEG_F;
            default: segs = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: multiplexed N-digit 7-segment display driver.
//   clk            : system clock.
//   reset          : asynchronous active-low reset.
//   load           : strobe, captures value/dp_mask into the shadow register.
//   value          : hex nibbles, value[3:0] is digit 0 (rightmost).
//   dp_mask        : decimal point enable per digit.
//   blank_lz       : leading-zero blanking enable (level).
//   blink_en       : blink enable (level).
//   digits         : one-hot active-high digit select.
//   segs           : active-high segments, segs[0]=a .. segs[6]=g.
//   dp             : active-high decimal point.
//   update_pending : a loaded value waits for the next frame boundary.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIG_PERIOD   = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [DIGIT_W*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]         dp_mask,
    input  logic                        blank_lz,
    input  logic                        blink_en,
    output logic [N_DIGITS-1:0]         digits,
    output logic [6:0]                  segs,
    output logic                        dp,
    output logic                        update_pending
);

    localparam int VAL_W = DIGIT_W * N_DIGITS;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = $clog2(DIG_PERIOD);
    localparam int BF_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIG_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);

    // Scan state
    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic                tc;
    logic                fb;

    // Value path
    logic [VAL_W-1:0]    shadow;
    logic [N_DIGITS-1:0] shadow_dp;
    logic [VAL_W-1:0]    active;
    logic [N_DIGITS-1:0] active_dp;
    logic [VAL_W-1:0]    active_next;
    logic [N_DIGITS-1:0] active_dp_next;

    // Blink state
    logic [BF_W-1:0]     frame_cnt;
    logic [0:0]          phase;
    logic [0:0]          phase_next;

    // Per-digit selection and decode
    logic [DIGIT_W-1:0]  nibble;
    logic                dp_sel;
    logic                blank_sel;
    logic [N_DIGITS-1:0] lz_blank;
    logic [6:0]          dec_segs;
    logic [6:0]          segs_next;
    logic                dp_next;

    // ------------------------------------------------------------------
    // Prescaler terminal count, frame boundary and next digit index
    // ------------------------------------------------------------------
    always_comb begin
        tc       = (presc == PRE_LAST);
        fb       = tc && (idx == IDX_LAST);
        idx_next = idx;
        if (tc) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            idx    <= '0;
            digits <= {{(N_DIGITS-1){1'b0}}, 1'b1};
        end else begin
            presc <= tc ? '0 : presc + 1'b1;
            idx   <= idx_next;
            if (tc) begin
                digits <= {digits[N_DIGITS-2:0], digits[N_DIGITS-1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Load / shadow handshake. The active value only changes on fb; a
    // load landing exactly on fb bypasses the shadow so it is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        active_next    = active;
        active_dp_next = active_dp;
        if (fb) begin
            if (load) begin
                active_next    = value;
                active_dp_next = dp_mask;
            end else if (update_pending) begin
                active_next    = shadow;
                active_dp_next = shadow_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow         <= '0;
            shadow_dp      <= '0;
            active         <= '0;
            active_dp      <= '0;
            update_pending <= 1'b0;
        end else begin
            active    <= active_next;
            active_dp <= active_dp_next;
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_mask;
            end
            if (fb) begin
                update_pending <= 1'b0;
            end else if (load) begin
                update_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink: frame counter and phase, held cleared/ON while disabled
    // ------------------------------------------------------------------
    always_comb begin
        phase_next = phase;
        if (!blink_en) begin
            phase_next = PHASE_ON;
        end else if (fb && (frame_cnt == BF_LAST)) begin
            phase_next = ~phase;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            phase     <= PHASE_ON;
        end else begin
            phase <= phase_next;
            if (!blink_en) begin
                frame_cnt <= '0;
            end else if (fb) begin
                frame_cnt <= (frame_cnt == BF_LAST) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit i>0 blanks when it and every higher
    // nibble of the value about to be shown are zero.
    // ------------------------------------------------------------------
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int unsigned i = N_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (active_next[i*DIGIT_W +: DIGIT_W] == '0);
            lz_blank[i] = zero_above;
        end
    end

    // Select the digit that becomes visible after this edge. Using the
    // next-state index/value keeps segs, dp and digits on the same edge.
    always_comb begin
        nibble    = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nibble    = active_next[i*DIGIT_W +: DIGIT_W];
                dp_sel    = active_dp_next[i];
                blank_sel = lz_blank[i];
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .segs   (dec_segs)
    );

    always_comb begin
        segs_next = dec_segs;
        dp_next   = dp_sel;
        if (blink_en && (phase_next == PHASE_OFF)) begin
            segs_next = SEG_BLANK;
            dp_next   = 1'b0;
        end else if (blank_lz && blank_sel) begin
            segs_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segs <= SEG_BLANK;
            dp   <= 1'b0;
        end else begin
            segs <= segs_next;
            dp   <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: directed + randomized bench for seg7_display_driver
// with a time-based behavioural model of the display.
module tb_seg7_display_driver;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int BF = 2;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  digits;
    logic [6:0]  segs;
    logic        dp;
    logic        update_pending;

    always #5 clk = ~clk;

    seg7_display_driver #(
        .N_DIGITS     (N),
        .DIG_PERIOD   (P),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .value          (value),
        .dp_mask        (dp_mask),
        .blank_lz       (blank_lz),
        .blink_en       (blink_en),
        .digits         (digits),
        .segs           (segs),
        .dp             (dp),
        .update_pending (update_pending)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: k = clock edges since reset release; displayed/pending values; blink.
    int          k;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_pval;
    logic [3:0]  m_pdp;
    bit          m_pend;
    bit          m_on;
    int          m_fcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_disp = '0;
        m_ddp  = '0;
        m_pval = '0;
        m_pdp  = '0;
        m_pend = 0;
        m_on   = 1;
        m_fcnt = 0;
    endtask

    task automatic model_edge();
        bit fb;
        k++;
        fb = (k % FRAME) == 0;
        if (load && fb) begin
            m_disp = value;
            m_ddp  = dp_mask;
            m_pend = 0;
        end else if (load) begin
            m_pval = value;
            m_pdp  = dp_mask;
            m_pend = 1;
        end else if (fb && m_pend) begin
            m_disp = m_pval;
            m_ddp  = m_pdp;
            m_pend = 0;
        end
        if (!blink_en) begin
            m_on   = 1;
            m_fcnt = 0;
        end else if (fb) begin
            m_fcnt++;
            if (m_fcnt == BF) begin
                m_fcnt = 0;
                m_on   = !m_on;
            end
        end
    endtask

    task automatic compare();
        int         idx;
        logic [6:0] es;
        logic       ed;
        bit         blanked;
        idx     = (k / P) % N;
        blanked = blank_lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
        es      = hex_tab[(m_disp >> (4 * idx)) & 16'hF];
        ed      = m_ddp[idx];
        if (blanked) es = 7'h00;
        if (blink_en && !m_on) begin
            es = 7'h00;
            ed = 1'b0;
        end
        check("digits", 32'(digits), 32'(4'b0001 << idx));
        check("segs", 32'(segs), 32'(es));
        check("dp", 32'(dp), 32'(ed));
        check("pending", 32'(update_pending), 32'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    // Called right after a step (posedge+1): asynchronous assert, check, release.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_digits"}, 32'(digits), 32'h1);
        check({tag, "_segs"}, 32'(segs), 32'h0);
        check({tag, "_dp"}, 32'(dp), 32'h0);
        check({tag, "_pending"}, 32'(update_pending), 32'h0);
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_mask  = '0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits), 32'h1);
        check("rst_segs", 32'(segs), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_pending", 32'(update_pending), 32'h0);
        reset = 1'b1;

        // Idle scanning after reset
        cycles(40);

        // Mid-frame load, shown from the next frame
        while ((k % FRAME) != 5) step();
        pulse_load(16'h12A0, 4'b0000);
        check("t2_pending", 32'(update_pending), 32'h1);
        cycles(40);

        // Leading-zero blanking with a decimal point on digit 1
        blank_lz = 1'b1;
        pulse_load(16'h0007, 4'b0010);
        cycles(40);
        blank_lz = 1'b0;
        cycles(20);

        // Load coinciding with the frame boundary
        while (((k + 1) % FRAME) != 0) step();
        pulse_load(16'hFFFF, 4'b0000);
        check("t4_pending", 32'(update_pending), 32'h0);
        check("t4_digits", 32'(digits), 32'h1);
        check("t4_segs", 32'(segs), 32'h71);

        // Two loads in one frame: last wins
        cycles(3);
        pulse_load(16'h1111, 4'b0000);
        cycles(2);
        pulse_load(16'h2222, 4'b0000);
        cycles(40);

        // Blink
        pulse_load(16'h8888, 4'b0000);
        cycles(20);
        blink_en = 1'b1;
        cycles(100);
        blink_en = 1'b0;
        cycles(P);
        check("t5_segs_after_blink", 32'(segs), 32'h7F);
        cycles(8);

        // Reset with a pending load
        while ((k % FRAME) != 5) step();
        pulse_load(16'h5555, 4'b1111);
        check("t6_pending", 32'(update_pending), 32'h1);
        cycles(2);
        do_reset("t6");
        cycles(40);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            load    = ($urandom_range(0, 11) == 0);
            value   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) value[15:4] = 12'h000;
            dp_mask = 4'($urandom);
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 90) == 0) blink_en = ~blink_en;
            step();
            if ($urandom_range(0, 400) == 0) do_reset("rnd_rst");
        end
        load = 1'b0;
        cycles(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
